nios_st_fifo_arbiter: RTL and testbench

Packet-aware round-robin arbiter that shares one Avalon-ST timing-adapter FIFO (37-bit beats, depth 16) between several streaming sources. It holds a grant for a whole packet (sop to eop) and throttles on the FIFO's `fill_level` watermark. A watchdog releases a source that stalls mid-packet. It sits between the requesting stream masters and the FIFO's `data_in` interface.

---
 rtl/nios_st_arb_pkg.sv | 9 +
 rtl/nios_st_rr_picker.sv | 25 ++
 rtl/nios_st_fifo_arbiter.sv | 110 +++++++++++
 tb/tb_nios_st_fifo_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_st_arb_pkg.sv
// Shared beat-field positions and FSM encoding for the Avalon-ST FIFO arbiter.
package nios_st_arb_pkg;
  localparam int SOP_BIT   = 32;
  localparam int EOP_BIT   = 33;
  localparam int EMPTY_LSB = 34;
  localparam int ERR_BIT   = 36;

  typedef enum logic {ST_IDLE, ST_LOCK} arb_state_e;
endpackage

// File: rtl/nios_st_rr_picker.sv
// Combinational round-robin picker: first set req bit after last_grant, wrapping.
module nios_st_rr_picker #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_grant,
  output logic [$clog2(NUM_SRC)-1:0] pick,
  output logic                       any
);
  localparam int IDX_W = $clog2(NUM_SRC);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick = last_grant;
    cand = last_grant;
    for (int off = NUM_SRC; off >= 1; off--) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_SRC);
      if (req[cand]) pick = cand;
    end
  end

  assign any = |req;
endmodule

// File: rtl/nios_st_fifo_arbiter.sv
// Packet-locked round-robin arbiter feeding one Avalon-ST FIFO, with fill-level
// throttle, mid-packet watchdog and orphan-beat discard.
module nios_st_fifo_arbiter
  import nios_st_arb_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int DATA_WIDTH  = 37,
  parameter int FILL_WIDTH  = 5,
  parameter int AFULL_LEVEL = 14,
  parameter int TIMEOUT     = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          fifo_in_valid,
  output logic [DATA_WIDTH-1:0]         fifo_in_data,
  input  logic                          fifo_in_ready,
  input  logic [FILL_WIDTH-1:0]         fifo_fill_level,
  output logic [NUM_SRC-1:0]            grant,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          drop_err
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(TIMEOUT);

  arb_state_e                           state;
  logic [IDX_W-1:0]                     last_grant, pick;
  logic                                 any;
  logic [CNT_W-1:0]                     wd_cnt;
  logic [NUM_SRC-1:0]                   sop, req, orphan;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   beats;
  logic                                 lock, throttle, owner_valid, owner_eop, accept;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign beats[i] = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign sop[i]   = beats[i][SOP_BIT];
  end

  assign lock   = (state == ST_LOCK);
  assign req    = src_valid & sop;
  assign orphan = src_valid & ~sop;

  nios_st_rr_picker #(.NUM_SRC(NUM_SRC)) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .pick       (pick),
    .any        (any)
  );

  // In LOCK the owner index is last_grant, so it doubles as the mux select.
  assign throttle      = (fifo_fill_level >= FILL_WIDTH'(AFULL_LEVEL));
  assign owner_valid   = src_valid[last_grant];
  assign owner_eop     = beats[last_grant][EOP_BIT];
  assign fifo_in_data  = beats[last_grant];
  assign fifo_in_valid = lock & owner_valid & ~throttle;
  assign accept        = lock & owner_valid & fifo_in_ready & ~throttle;
  assign busy          = lock;

  always_comb begin
    src_ready = '0;
    if (lock) src_ready[last_grant] = fifo_in_ready & ~throttle;
    else      src_ready = orphan;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_grant  <= IDX_W'(NUM_SRC-1);
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      drop_err    <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      drop_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          wd_cnt   <= '0;
          drop_err <= |orphan;
          if (any) begin
            state      <= ST_LOCK;
            last_grant <= pick;
            grant      <= NUM_SRC'(1) << pick;
          end
        end
        ST_LOCK: begin
          if (accept && owner_eop) begin
            state  <= ST_IDLE;
            grant  <= '0;
            wd_cnt <= '0;
          end else if (owner_valid) begin
            // Backpressure or throttle with data pending is not a source stall.
            wd_cnt <= '0;
          end else if (wd_cnt == CNT_W'(TIMEOUT-1)) begin
            state       <= ST_IDLE;
            grant       <= '0;
            wd_cnt      <= '0;
            timeout_err <= 1'b1;
          end else if (wd_cnt != {CNT_W{1'b1}}) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_nios_st_fifo_arbiter.sv
// Self-checking bench: table vectors, directed corner sequences and random traffic
// compared each cycle against a packet-level reference model.
module tb_nios_st_fifo_arbiter;
  localparam int N = 4, W = 37, FW = 5, AF = 14, TO = 64;

  logic            clk = 1'b0, reset_n = 1'b0;
  logic [N-1:0]    src_valid, src_ready, grant;
  logic [N*W-1:0]  src_data;
  logic            fifo_in_valid, fifo_in_ready, busy, timeout_err, drop_err;
  logic [W-1:0]    fifo_in_data;
  logic [FW-1:0]   fifo_fill_level;

  always #5 clk = ~clk;

  nios_st_fifo_arbiter #(.NUM_SRC(N), .DATA_WIDTH(W), .FILL_WIDTH(FW),
                         .AFULL_LEVEL(AF), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .fifo_in_valid(fifo_in_valid), .fifo_in_data(fifo_in_data),
    .fifo_in_ready(fifo_in_ready), .fifo_fill_level(fifo_fill_level), .grant(grant),
    .busy(busy), .timeout_err(timeout_err), .drop_err(drop_err)
  );

  int checks = 0, errors = 0;
  logic [W-1:0] q[N][$];
  logic [N-1:0] en, prev_grant;
  // reference model state: locked flag, owner, last winner, consecutive idle cycles
  int m_lock, m_owner, m_last, m_idle;
  bit m_tp, m_dp;
  int t_cnt, d_cnt, acc_cnt;
  logic [N-1:0] gq[$];

  typedef struct { logic [N-1:0] valid, sop, rdy, gnt; bit drop; } vec_t;
  vec_t tbl[7];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(bit s, bit e);
    return {3'($urandom), e, s, 32'($urandom)};
  endfunction

  task automatic add_pkt(int s, int len);
    for (int b = 0; b < len; b++) q[s].push_back(mk(b == 0, b == len-1));
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_valid[i]       = en[i] && (q[i].size() > 0);
      src_data[i*W +: W] = (q[i].size() > 0) ? q[i][0] : '0;
    end
  endtask

  task automatic check_cycle(output logic [N-1:0] pop);
    logic [N-1:0] sop, eop, rdy;
    bit thr, fv;
    int nxt;
    for (int i = 0; i < N; i++) begin
      sop[i] = src_data[i*W + 32];
      eop[i] = src_data[i*W + 33];
    end
    thr = (fifo_fill_level >= AF);
    rdy = '0;
    if (m_lock != 0) begin
      fv = src_valid[m_owner] && !thr;
      rdy[m_owner] = fifo_in_ready && !thr;
    end else begin
      fv  = 1'b0;
      rdy = src_valid & ~sop;
    end
    chk("fifo_in_valid", fifo_in_valid, fv);
    chk("src_ready", src_ready, rdy);
    chk("grant", grant, (m_lock != 0) ? (1 << m_owner) : 0);
    chk("busy", busy, m_lock);
    chk("timeout_err", timeout_err, m_tp);
    chk("drop_err", drop_err, m_dp);
    if (fv) chk("fifo_in_data", fifo_in_data, src_data[m_owner*W +: W]);
    if (timeout_err) t_cnt++;
    if (drop_err) d_cnt++;
    if (fifo_in_valid && fifo_in_ready) acc_cnt++;
    if (grant != 0 && grant !== prev_grant) gq.push_back(grant);
    prev_grant = grant;
    pop = src_valid & rdy;
    m_tp = 0; m_dp = 0;
    if (m_lock == 0) begin
      m_dp = |(src_valid & ~sop);
      nxt = -1;
      for (int k = N; k >= 1; k--)
        if (src_valid[(m_last+k)%N] && sop[(m_last+k)%N]) nxt = (m_last+k)%N;
      if (nxt >= 0) begin m_lock = 1; m_owner = nxt; m_last = nxt; m_idle = 0; end
    end else if (src_valid[m_owner]) begin
      m_idle = 0;
      if (fifo_in_ready && !thr && eop[m_owner]) m_lock = 0;
    end else begin
      m_idle++;
      if (m_idle == TO) begin m_lock = 0; m_tp = 1; m_idle = 0; end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] pop;
    drive();
    @(negedge clk);
    check_cycle(pop);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (pop[i]) void'(q[i].pop_front());
  endtask

  task automatic do_reset();
    reset_n = 1'b0; en = '1; fifo_in_ready = 1'b1; fifo_fill_level = '0;
    for (int s = 0; s < N; s++) q[s].delete();
    m_lock = 0; m_owner = 0; m_last = N-1; m_idle = 0; m_tp = 0; m_dp = 0;
    prev_grant = '0; gq.delete();
    drive();
    @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_errs", {timeout_err, drop_err}, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1] = '{4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0};
    tbl[2] = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b1};
    tbl[3] = '{4'b0110, 4'b0100, 4'b0010, 4'b0100, 1'b1};
    tbl[4] = '{4'b1010, 4'b1010, 4'b0000, 4'b0010, 1'b0};
    tbl[5] = '{4'b1111, 4'b1100, 4'b0011, 4'b0100, 1'b1};
    tbl[6] = '{4'b1000, 4'b1000, 4'b0000, 4'b1000, 1'b0};
    src_valid = '0; src_data = '0;

    // IDLE arbitration and orphan handling straight out of reset
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int s = 0; s < N; s++)
        if (tbl[v].valid[s]) q[s].push_back(mk(tbl[v].sop[s], 1'b1));
      drive();
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", v), src_ready, tbl[v].rdy);
      chk($sformatf("tbl%0d_fvalid", v), fifo_in_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("tbl%0d_grant", v), grant, tbl[v].gnt);
      chk($sformatf("tbl%0d_drop", v), drop_err, tbl[v].drop);
    end

    // fairness: 3-beat packets from everyone, rotation 0,1,2,3,0
    do_reset();
    for (int s = 0; s < N; s++) add_pkt(s, 3);
    add_pkt(0, 3);
    repeat (24) cycle();
    chk("fair_count", gq.size(), 5);
    for (int k = 0; k < 5 && k < gq.size(); k++)
      chk($sformatf("fair_grant%0d", k), gq[k], (k == 4) ? 1 : (1 << k));

    // watermark throttle held for 100 cycles mid-packet
    do_reset();
    add_pkt(1, 6); acc_cnt = 0; t_cnt = 0;
    repeat (2) cycle();
    fifo_fill_level = 5'd14;
    repeat (100) cycle();
    chk("wm_no_timeout", t_cnt, 0);
    chk("wm_held_beats", acc_cnt, 1);
    fifo_fill_level = 5'd13;
    repeat (8) cycle();
    chk("wm_all_beats", acc_cnt, 6);

    // watchdog abort, then source 2 picks up
    do_reset();
    add_pkt(1, 3); t_cnt = 0;
    repeat (2) cycle();
    en[1] = 1'b0;
    add_pkt(2, 2);
    repeat (70) cycle();
    chk("to_pulses", t_cnt, 1);
    chk("to_grants", gq.size(), 2);
    if (gq.size() == 2) chk("to_next_owner", gq[1], 4'b0100);

    // orphan beat in IDLE
    do_reset();
    q[3].push_back(mk(1'b0, 1'b0)); d_cnt = 0;
    repeat (3) cycle();
    chk("orphan_drops", d_cnt, 1);
    chk("orphan_consumed", q[3].size(), 0);

    // single-beat packet held by fifo backpressure
    do_reset();
    fifo_in_ready = 1'b0; add_pkt(0, 1); acc_cnt = 0;
    repeat (4) cycle();
    chk("sb_held", acc_cnt, 0);
    fifo_in_ready = 1'b1;
    repeat (2) cycle();
    chk("sb_sent", acc_cnt, 1);
    @(negedge clk);
    chk("sb_idle", busy, 0);
    @(posedge clk); #1;

    // async reset mid-packet on source 0; next grant must go back to source 0
    do_reset();
    add_pkt(0, 5);
    repeat (3) cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_grant", grant, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_fvalid", fifo_in_valid, 0);
    do_reset();
    add_pkt(1, 1); add_pkt(0, 1);
    repeat (3) cycle();
    chk("rst_first_grant", (gq.size() > 0) ? gq[0] : 0, 4'b0001);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < N; s++)
        if (q[s].size() == 0 && $urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 9) == 0) q[s].push_back(mk(1'b0, $urandom_range(0, 1) != 0));
          else add_pkt(s, $urandom_range(1, 4));
        end
      en = ($urandom_range(0, 7) == 0) ? N'($urandom) : '1;
      fifo_in_ready = ($urandom_range(0, 3) != 0);
      fifo_fill_level = ($urandom_range(0, 4) == 0) ? FW'($urandom_range(12, 16))
                                                    : FW'($urandom_range(0, 13));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
